// File: rtl/alu_cmd_sequencer_if.sv
// rtl/alu_cmd_sequencer_if.sv - command and response valid/ready channels of the ALU sequencer
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [WIDTH-1:0] cmd_data;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_ovf;

    // Client side: issues commands, consumes responses
    modport master (
        output cmd_valid, cmd_op, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_ovf
    );

    // Sequencer side: accepts commands, produces responses
    modport slave (
        input  cmd_valid, cmd_op, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_ovf
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - accumulator command sequencer driving an external 4-bit ALU (option: ALU_SAT_EN clamps ADD/SUB overflow)
module alu_cmd_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    alu_cmd_sequencer_if.slave bus,
    output logic [WIDTH-1:0]  o_alu_a,
    output logic [WIDTH-1:0]  o_alu_b,
    output logic [2:0]        o_alu_op,
    input  logic [WIDTH-1:0]  i_alu_out,
    input  logic              i_alu_overflow,
    output logic              o_sticky_ovf,
    output logic [CNT_W-1:0]  o_op_count
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_CLRF = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_rsp_valid;
    logic [WIDTH-1:0] r_rsp_data;
    logic             r_rsp_ovf;
    logic             r_sticky_ovf;
    logic [CNT_W-1:0] r_op_count;

    logic [WIDTH-1:0] w_result;

`ifdef ALU_SAT_EN
    logic             w_is_arith;
    logic             w_clamp;
    logic [WIDTH-1:0] w_limit;

    // Signed overflow on ADD/SUB can only go past the limit on the side of operand A's sign
    assign w_is_arith = (r_alu_op == OP_ADD) || (r_alu_op == OP_SUB);
    assign w_clamp    = w_is_arith && i_alu_overflow;
    assign w_limit    = r_alu_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                         : {1'b0, {(WIDTH-1){1'b1}}};
    assign w_result   = w_clamp ? w_limit : i_alu_out;
`else
    assign w_result   = i_alu_out;
`endif

    // Ready only in IDLE, and forced low while reset is held so nothing is accepted during reset
    assign bus.cmd_ready = (r_state == S_IDLE) && i_rst_n;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rsp_ovf   = r_rsp_ovf;
    assign o_alu_a       = r_alu_a;
    assign o_alu_b       = r_alu_b;
    assign o_alu_op      = r_alu_op;
    assign o_sticky_ovf  = r_sticky_ovf;
    assign o_op_count    = r_op_count;

    // Sequencer FSM: accept command, run one ALU cycle if needed, hold response until taken
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_op     <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_ovf    <= 1'b0;
            r_sticky_ovf <= 1'b0;
            r_op_count   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid) begin
                        if (bus.cmd_op == OP_LOAD) begin
                            r_acc       <= bus.cmd_data;
                            r_rsp_data  <= bus.cmd_data;
                            r_rsp_ovf   <= 1'b0;
                            r_rsp_valid <= 1'b1;
                            r_state     <= S_RESP;
                        end else if (bus.cmd_op == OP_CLRF) begin
                            r_sticky_ovf <= 1'b0;
                            r_rsp_data   <= r_acc;
                            r_rsp_ovf    <= 1'b0;
                            r_rsp_valid  <= 1'b1;
                            r_state      <= S_RESP;
                        end else begin
                            // Op 101 is forwarded as-is; the ALU answers it with zero
                            r_alu_a  <= r_acc;
                            r_alu_b  <= bus.cmd_data;
                            r_alu_op <= bus.cmd_op;
                            r_state  <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_acc        <= w_result;
                    r_rsp_data   <= w_result;
                    r_rsp_ovf    <= i_alu_overflow;
                    r_sticky_ovf <= r_sticky_ovf | i_alu_overflow;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        if (r_op_count != {CNT_W{1'b1}}) begin
                            r_op_count <= r_op_count + {{(CNT_W-1){1'b0}}, 1'b1};
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb/tb_alu_cmd_sequencer.sv - self-checking bench for alu_cmd_sequencer with a behavioural 4-bit ALU
module tb_alu_cmd_sequencer;
    localparam int W  = 4;
    localparam int CW = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [2:0]    alu_op;
    logic [W-1:0]  alu_out;
    logic          alu_ovf;
    logic          sticky;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_cmd_sequencer_if #(.WIDTH(W)) bus ();

    alu_cmd_sequencer #(.WIDTH(W), .CNT_W(CW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .bus            (bus.slave),
        .o_alu_a        (alu_a),
        .o_alu_b        (alu_b),
        .o_alu_op       (alu_op),
        .i_alu_out      (alu_out),
        .i_alu_overflow (alu_ovf),
        .o_sticky_ovf   (sticky),
        .o_op_count     (op_count)
    );

    // Reference combinational ALU acting as the responder
    always_comb begin
        alu_out = '0;
        alu_ovf = 1'b0;
        case (alu_op)
            3'b000: begin
                alu_out = alu_a + alu_b;
                alu_ovf = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
            end
            3'b001: begin
                alu_out = alu_a - alu_b;
                alu_ovf = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
            end
            3'b010: alu_out = alu_a & alu_b;
            3'b011: alu_out = alu_a | alu_b;
            3'b100: alu_out = alu_a ^ alu_b;
            default: begin
                alu_out = '0;
                alu_ovf = 1'b0;
            end
        endcase
    end

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] data;
        logic [W-1:0] exp_d;
        logic         exp_ovf;
        logic         exp_st;
        int           bp;
    } vec_t;

    typedef struct {
        logic [W-1:0] d;
        logic         ovf;
        logic         st;
    } exp_t;

`ifdef ALU_SAT_EN
    localparam logic [W-1:0] R_ADD_POS = 4'b0111;
    localparam logic [W-1:0] R_SUB_NEG = 4'b1000;
    localparam logic [W-1:0] R_ADD_NEG = 4'b1000;
`else
    localparam logic [W-1:0] R_ADD_POS = 4'b1001;
    localparam logic [W-1:0] R_SUB_NEG = 4'b0111;
    localparam logic [W-1:0] R_ADD_NEG = 4'b0000;
`endif

    localparam int NV = 16;
    vec_t          vecs [NV];
    exp_t          sb_q [$];
    int            n_err = 0;
    int            n_chk = 0;
    logic [W-1:0]  m_acc = '0;
    logic [CW-1:0] exp_cnt = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
    endtask

    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] data,
                          input logic [W-1:0] exp_d, input logic exp_ovf,
                          input logic exp_st, input int bp);
        exp_t e;
        logic [W-1:0] held;
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_data  = data;
        sb_q.push_back('{exp_d, exp_ovf, exp_st});
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        if (op < 3'b110) begin
            check("issue_alu_a",   {28'd0, alu_a}, {28'd0, m_acc});
            check("issue_alu_b",   {28'd0, alu_b}, {28'd0, data});
            check("issue_alu_op",  {29'd0, alu_op}, {29'd0, op});
            check("issue_no_rsp",  {31'd0, bus.rsp_valid}, 32'd0);
            check("issue_cmd_rdy", {31'd0, bus.cmd_ready}, 32'd0);
            @(posedge clk); #1;
        end
        check("rsp_latency", {31'd0, bus.rsp_valid}, 32'd1);
        check("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            check("rsp_data",   {28'd0, bus.rsp_data}, {28'd0, e.d});
            check("rsp_ovf",    {31'd0, bus.rsp_ovf}, {31'd0, e.ovf});
            check("sticky_ovf", {31'd0, sticky}, {31'd0, e.st});
        end
        held = bus.rsp_data;
        for (int k = 0; k < bp; k++) begin
            // Offer a competing LOAD while the response is stalled; it must be ignored
            bus.cmd_valid = 1'b1;
            bus.cmd_op    = 3'b111;
            bus.cmd_data  = 4'b1111;
            @(posedge clk); #1;
            check("bp_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("bp_rsp_data",  {28'd0, bus.rsp_data}, {28'd0, held});
            check("bp_cmd_ready", {31'd0, bus.cmd_ready}, 32'd0);
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        if (exp_cnt != {CW{1'b1}}) exp_cnt = exp_cnt + 1'b1;
        check("rsp_done",  {31'd0, bus.rsp_valid}, 32'd0);
        check("op_count",  {24'd0, op_count}, {24'd0, exp_cnt});
        m_acc = exp_d;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_alu_a"},     {28'd0, alu_a}, 32'd0);
        check({tag, "_alu_b"},     {28'd0, alu_b}, 32'd0);
        check({tag, "_alu_op"},    {29'd0, alu_op}, 32'd0);
        check({tag, "_rsp_valid"}, {31'd0, bus.rsp_valid}, 32'd0);
        check({tag, "_rsp_data"},  {28'd0, bus.rsp_data}, 32'd0);
        check({tag, "_rsp_ovf"},   {31'd0, bus.rsp_ovf}, 32'd0);
        check({tag, "_sticky"},    {31'd0, sticky}, 32'd0);
        check({tag, "_op_count"},  {24'd0, op_count}, 32'd0);
        check({tag, "_cmd_ready"}, {31'd0, bus.cmd_ready}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'b111, 4'b0101, 4'b0101,   1'b0, 1'b0, 0};
        vecs[1]  = '{3'b000, 4'b0100, R_ADD_POS, 1'b1, 1'b1, 0};
        vecs[2]  = '{3'b111, 4'b1000, 4'b1000,   1'b0, 1'b1, 0};
        vecs[3]  = '{3'b001, 4'b0001, R_SUB_NEG, 1'b1, 1'b1, 0};
        vecs[4]  = '{3'b110, 4'b0000, R_SUB_NEG, 1'b0, 1'b0, 0};
        vecs[5]  = '{3'b111, 4'b1100, 4'b1100,   1'b0, 1'b0, 0};
        vecs[6]  = '{3'b010, 4'b1010, 4'b1000,   1'b0, 1'b0, 0};
        vecs[7]  = '{3'b011, 4'b0011, 4'b1011,   1'b0, 1'b0, 0};
        vecs[8]  = '{3'b100, 4'b1111, 4'b0100,   1'b0, 1'b0, 0};
        vecs[9]  = '{3'b101, 4'b0110, 4'b0000,   1'b0, 1'b0, 0};
        vecs[10] = '{3'b111, 4'b0010, 4'b0010,   1'b0, 1'b0, 0};
        vecs[11] = '{3'b000, 4'b0011, 4'b0101,   1'b0, 1'b0, 5};
        vecs[12] = '{3'b000, 4'b0000, 4'b0101,   1'b0, 1'b0, 0};
        vecs[13] = '{3'b111, 4'b1000, 4'b1000,   1'b0, 1'b0, 0};
        vecs[14] = '{3'b000, 4'b1000, R_ADD_NEG, 1'b1, 1'b1, 0};
        vecs[15] = '{3'b110, 4'b0101, R_ADD_NEG, 1'b0, 1'b0, 0};

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;

        // Reset state
        #1 rst_n = 1'b0;
        #1;
        check_all_zero("reset");
        @(posedge clk); @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_cmd_ready", {31'd0, bus.cmd_ready}, 32'd1);

        // Table-driven command sequence
        for (int i = 0; i < NV; i++) begin
            do_cmd(vecs[i].op, vecs[i].data, vecs[i].exp_d,
                   vecs[i].exp_ovf, vecs[i].exp_st, vecs[i].bp);
        end

        // Reset asserted while an ADD is in its ISSUE cycle
        wait_ready();
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 3'b000;
        bus.cmd_data  = 4'b0011;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("abort_issue_alu_b", {28'd0, alu_b}, 32'd3);
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            check("abort_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        m_acc   = '0;
        exp_cnt = '0;
        sb_q.delete();
        do_cmd(3'b000, 4'b0001, 4'b0001, 1'b0, 1'b0, 0);

        // Counter saturation over a long run of LOADs
        for (int i = 0; i < 260; i++) begin
            do_cmd(3'b111, 4'(i), 4'(i), 1'b0, 1'b0, 0);
        end
        check("op_count_sat", {24'd0, op_count}, 32'd255);
        check("sb_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
